// File: rtl/riscv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_pkg: shared fetch/decode types and constants               |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] Instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_queue_mem: DEPTH-entry register array, 1W sync / 1R async  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_queue_mem
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  fetch_entry_t       wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output fetch_entry_t       rdata_o
);

    // Storage is never reset; occupancy logic in the parent masks stale data.
    fetch_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | instr_fetch_queue: fetch->decode prefetch FIFO with 1-cycle flush |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module instr_fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [XLEN-1:0]          InstrF,
    input  logic [XLEN-1:0]          PCF,
    input  logic                     ValidF,
    output logic                     ReadyF,
    output logic [XLEN-1:0]          InstrD,
    output logic [XLEN-1:0]          PCD,
    output logic                     ValidD,
    input  logic                     StallD,
    input  logic                     FlushD,
    output logic [$clog2(DEPTH):0]   CountQ
);

    localparam int             AW         = $clog2(DEPTH);
    localparam int             CW         = AW + 1;
    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ready_q,  ready_d;

    logic          push;
    logic          pop;
    fetch_entry_t  wdata;
    fetch_entry_t  head;

    assign ValidD = (count_q != '0);
    assign push   = ValidF & ready_q & ~FlushD;
    assign pop    = ValidD & ~StallD & ~FlushD;

    assign wdata.PC    = PCF;
    assign wdata.Instr = InstrF;

    fetch_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (FlushD) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        // Registered so ReadyF has no path from StallD/FlushD.
        ready_d = (count_d != FULL_COUNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    assign ReadyF = ready_q;
    assign CountQ = count_q;
    assign InstrD = ValidD ? head.Instr : NOP_INSTR;
    assign PCD    = ValidD ? head.PC    : '0;

endmodule
`default_nettype wire
